// File: rtl/fracnet_pkg.sv
// FracNet MAC shared types, parameter limits and saturation bounds.
package fracnet_pkg;

  localparam int MUL_STAGES_MIN = 1;
  localparam int MUL_STAGES_MAX = 3;
  localparam int ACC_W_DEF      = 40;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  function automatic longint sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

endpackage

// File: rtl/fracnet_mul_pipe.sv
// Signed multiplier with STAGES output registers, kept alone for DSP mapping.
module fracnet_mul_pipe #(
  parameter int A_W    = 16,
  parameter int B_W    = 12,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic signed [A_W-1:0]    i_a,
  input  logic signed [B_W-1:0]    i_b,
  output logic signed [A_W+B_W-1:0] o_p
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] w_a;
  logic signed [P_W-1:0] w_b;
  logic signed [P_W-1:0] r_p [STAGES];

  assign w_a = P_W'(i_a);
  assign w_b = P_W'(i_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) r_p[k] <= '0;
    end else if (ce) begin
      r_p[0] <= w_a * w_b;
      for (int k = 1; k < STAGES; k++) r_p[k] <= r_p[k-1];
    end
  end

  assign o_p = r_p[STAGES-1];

endmodule

// File: rtl/fracnet_mac_pipe.sv
// Pipelined signed MAC: framed accumulate, then shift, round-half-up
// and saturate to OUT_W.
module fracnet_mac_pipe
  import fracnet_pkg::*;
#(
  parameter int A_W        = 16,
  parameter int B_W        = 12,
  parameter int MUL_STAGES = 2,
  parameter int ACC_W      = 40,
  parameter int SHIFT      = 8,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam int P_W = A_W + B_W;
  localparam logic signed [ACC_W:0] L_MAX = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] L_MIN = (ACC_W+1)'(sat_min(OUT_W));
  localparam logic signed [ACC_W:0] L_RND = ((ACC_W+1)'(1) << SHIFT) >> 1;

  if (MUL_STAGES < MUL_STAGES_MIN || MUL_STAGES > MUL_STAGES_MAX ||
      ACC_W < P_W || SHIFT < 0 || SHIFT > ACC_W - OUT_W) begin : g_bad
    $error("fracnet_mac_pipe: illegal parameter combination");
  end

  // One extra bit so the rounding add can never wrap.
  function automatic logic [OUT_W:0] rnd_sat(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W:0] s;
    s = ((ACC_W+1)'(a) + L_RND) >>> SHIFT;
    if (s > L_MAX) return {1'b1, OUT_W'(L_MAX)};
    if (s < L_MIN) return {1'b1, OUT_W'(L_MIN)};
    return {1'b0, OUT_W'(s)};
  endfunction

  logic signed [P_W-1:0]   w_p;
  logic signed [ACC_W-1:0] w_pe;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [OUT_W:0]          w_res;
  logic                    w_v;
  logic                    w_f;
  logic                    w_l;

  logic [2:0]              r_flg [MUL_STAGES];
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_fin;

  fracnet_mul_pipe #(
    .A_W    (A_W),
    .B_W    (B_W),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .i_a   (din0),
    .i_b   (din1),
    .o_p   (w_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MUL_STAGES; k++) r_flg[k] <= '0;
    end else if (ce) begin
      r_flg[0] <= {in_valid, in_valid & in_first, in_valid & in_last};
      for (int k = 1; k < MUL_STAGES; k++) r_flg[k] <= r_flg[k-1];
    end
  end

  assign w_v = r_flg[MUL_STAGES-1][2];
  assign w_f = r_flg[MUL_STAGES-1][1];
  assign w_l = r_flg[MUL_STAGES-1][0];

  assign w_pe       = ACC_W'(w_p);
  assign w_acc_next = w_f ? w_pe : r_acc + w_pe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_fin <= 1'b0;
    end else if (ce) begin
      r_fin <= w_v & w_l;
      if (w_v) r_acc <= w_acc_next;
    end
  end

  assign w_res = rnd_sat(r_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= r_fin;
      if (r_fin) {ovf, dout} <= w_res;
    end
  end

endmodule

// File: tb/tb_fracnet_mac_pipe.sv
// Scoreboard bench: six MAC instances (MUL_STAGES 1..3 x SHIFT 0/8)
// share one stimulus stream and are checked against an arithmetic model.
module tb_fracnet_mac_pipe;

  localparam int NC = 6;
  localparam int MS [NC] = '{1, 2, 3, 1, 2, 3};
  localparam int SH [NC] = '{0, 0, 0, 8, 8, 8};

  logic               clk      = 1'b0;
  logic               reset    = 1'b1;
  logic               ce       = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_first = 1'b0;
  logic               in_last  = 1'b0;
  logic signed [15:0] din0     = '0;
  logic signed [11:0] din1     = '0;

  logic               ov    [NC];
  logic signed [15:0] dq    [NC];
  logic               ovf_q [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    fracnet_mac_pipe #(
      .A_W        (16),
      .B_W        (12),
      .MUL_STAGES (MS[g]),
      .ACC_W      (40),
      .SHIFT      (SH[g]),
      .OUT_W      (16)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_last   (in_last),
      .din0      (din0),
      .din1      (din1),
      .out_valid (ov[g]),
      .dout      (dq[g]),
      .ovf       (ovf_q[g])
    );
  end

  typedef struct {
    int     d;
    bit     o;
    longint due;
  } exp_t;

  exp_t   sb [NC][$];
  longint acc_m  = 0;
  longint ce_cnt = 0;
  int     checks = 0;
  int     errors = 0;
  bit     done   = 0;

  task automatic chk(input string nm, input int c,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d (M=%0d S=%0d): got %0d want %0d",
               nm, c, MS[c], SH[c], act, exp);
    end
  endtask

  // Model and monitor: frame sums by plain arithmetic, results queued
  // with the ce-edge index they are due on.
  initial begin : mon
    bit     ce_edge;
    longint p;
    longint r;
    exp_t   e;
    forever begin
      @(posedge clk or posedge reset);
      ce_edge = 0;
      if (reset) begin
        acc_m = 0;
        for (int c = 0; c < NC; c++) sb[c].delete();
      end else if (clk && ce) begin
        ce_edge = 1;
        ce_cnt++;
        if (in_valid) begin
          p     = longint'(din0) * longint'(din1);
          acc_m = in_first ? p : acc_m + p;
          acc_m = (acc_m <<< 24) >>> 24;
          if (in_last) begin
            for (int c = 0; c < NC; c++) begin
              r = acc_m + (SH[c] > 0 ? (64'sd1 <<< (SH[c] - 1)) : 64'sd0);
              r = r >>> SH[c];
              e.o   = (r > 32767) || (r < -32768);
              e.d   = r > 32767 ? 32767 : (r < -32768 ? -32768 : int'(r));
              e.due = ce_cnt + MS[c] + 1;
              sb[c].push_back(e);
            end
          end
        end
      end
      #1;
      for (int c = 0; c < NC; c++) begin
        if (reset) begin
          chk("rst_valid", c, ov[c], 0);
          chk("rst_dout", c, dq[c], 0);
          chk("rst_ovf", c, ovf_q[c], 0);
        end else if (ce_edge) begin
          if (ov[c]) begin
            if (sb[c].size() == 0) begin
              chk("spurious_valid", c, ov[c], 0);
            end else begin
              e = sb[c].pop_front();
              chk("dout", c, dq[c], e.d);
              chk("ovf", c, ovf_q[c], e.o);
              chk("latency", c, ce_cnt, e.due);
            end
          end else if (sb[c].size() > 0 && sb[c][0].due <= ce_cnt) begin
            chk("missing_valid", c, ov[c], 1);
            void'(sb[c].pop_front());
          end
        end
      end
      if (done) break;
    end
    for (int c = 0; c < NC; c++) chk("drain", c, sb[c].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic term(input int a, input int b, input bit f, input bit l);
    @(negedge clk);
    ce       = 1'b1;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    din0     = 16'(a);
    din1     = 12'(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce       = 1'b1;
      in_valid = 1'b0;
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      din0     = 16'($urandom);
      din1     = 12'($urandom);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      ce       = 1'b0;
      in_valid = 1'b1;
      in_first = 1'($urandom);
      in_last  = 1'b1;
      din0     = 16'($urandom);
      din1     = 12'($urandom);
    end
  endtask

  task automatic rnd(input int n);
    repeat (n) begin
      @(negedge clk);
      ce       = $urandom_range(0, 7) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_first = $urandom_range(0, 4) == 0;
      in_last  = $urandom_range(0, 4) == 0;
      case ($urandom_range(0, 7))
        0:       din0 = 16'sh7fff;
        1:       din0 = -16'sh8000;
        default: din0 = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       din1 = 12'sh7ff;
        1:       din1 = -12'sh800;
        default: din1 = 12'($urandom);
      endcase
    end
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    term(-3, 5, 1, 1);
    idle(5);
    for (int i = 0; i < 4; i++) term(100, 100, i == 0, i == 3);
    idle(5);
    term(32767, 2047, 1, 0);
    term(32767, 2047, 0, 1);
    term(-32768, 2047, 1, 0);
    term(-32768, 2047, 0, 1);
    idle(5);
    term(1, 1, 1, 0);
    term(2, 2, 0, 1);
    term(3, 3, 1, 1);
    idle(5);
    term(7, -9, 1, 0);
    term(11, 13, 0, 0);
    gap(3);
    term(-5, 6, 0, 1);
    gap(3);
    idle(6);
    rnd(400);
    idle(6);
    term(50, -20, 1, 0);
    term(9, 9, 0, 0);
    term(4, 4, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    term(3, 4, 0, 1);
    idle(6);
    rnd(300);
    idle(10);
    done = 1'b1;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
